// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter: FSM states, read-data owner tags
// and the rd_wr_mem size encoding understood by the data memory and decoder.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        NORMAL,
        EXT_FORCE,
        EXT_LOCK
    } arb_state_e;

    typedef enum logic {
        OWN_CORE,
        OWN_EXT
    } owner_e;

    typedef struct packed {
        logic   valid;
        owner_e owner;
    } tag_t;

    // rd_wr_mem: bit 2 selects zero-extension on loads, bits 1:0 the access size
    localparam logic [2:0] RW_BYTE   = 3'b000;
    localparam logic [2:0] RW_HALF   = 3'b001;
    localparam logic [2:0] RW_WORD   = 3'b010;
    localparam logic [2:0] RW_BYTE_U = 3'b100;
    localparam logic [2:0] RW_HALF_U = 3'b101;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundle of the two requester ports and the data-memory port around the arbiter.
// slave is the arbiter's view; master is the view of the core, loader and memory.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              core_req;
    logic              core_we;
    logic [2:0]        core_size;
    logic [ADDR_W-1:0] core_addr;
    logic [DATA_W-1:0] core_wdata;
    logic              core_gnt;
    logic              core_stall;
    logic              core_rvalid;
    logic [DATA_W-1:0] core_rdata;

    logic              ext_req;
    logic              ext_we;
    logic [2:0]        ext_size;
    logic [ADDR_W-1:0] ext_addr;
    logic [DATA_W-1:0] ext_wdata;
    logic              ext_lock;
    logic              ext_gnt;
    logic              ext_rvalid;
    logic [DATA_W-1:0] ext_rdata;

    logic              mem_en;
    logic              mem_wr;
    logic [2:0]        mem_rd_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  core_req, core_we, core_size, core_addr, core_wdata,
        output core_gnt, core_stall, core_rvalid, core_rdata,
        input  ext_req, ext_we, ext_size, ext_addr, ext_wdata, ext_lock,
        output ext_gnt, ext_rvalid, ext_rdata,
        output mem_en, mem_wr, mem_rd_wr, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output core_req, core_we, core_size, core_addr, core_wdata,
        input  core_gnt, core_stall, core_rvalid, core_rdata,
        output ext_req, ext_we, ext_size, ext_addr, ext_wdata, ext_lock,
        input  ext_gnt, ext_rvalid, ext_rdata,
        input  mem_en, mem_wr, mem_rd_wr, mem_addr, mem_wdata,
        output mem_rdata
    );

endinterface

// File: rtl/arb_tag_pipe.sv
// MEM_LAT-deep shift register carrying {valid, owner} for each issued access,
// so returning read data can be steered to the requester that issued it.
module arb_tag_pipe
    import dmem_arb_pkg::*;
#(
    parameter int MEM_LAT = 1
) (
    input  logic clock,
    input  logic reset,
    input  tag_t tag_in,
    output tag_t tag_out
);

    tag_t [MEM_LAT-1:0] stage;

    // NOTE: this storage is reset, unlike a data RAM, because a stale valid bit
    // would return phantom read data after reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stage <= '0;
        end else begin
            // NOTE: non-blocking so every stage shifts from the old value.
            stage[0] <= tag_in;
            for (int i = 1; i < MEM_LAT; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign tag_out = stage[MEM_LAT-1];

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates the data-memory port between the core memory stage and an external
// loader/debug master, with starvation-forced and locked external service.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 1,  // legal range 1..4
    parameter int STARVE_LIM = 8
) (
    input  logic           clock,
    input  logic           reset,
    dmem_arbiter_if.slave  bus
);

    localparam int              CNT_W = $clog2(STARVE_LIM + 1);
    localparam logic [CNT_W-1:0] LIM  = CNT_W'(STARVE_LIM);

    arb_state_e       state;
    logic [CNT_W-1:0] starve_cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             core_gnt;
    logic             ext_gnt;
    logic             ext_wait;
    tag_t             tag_in;
    tag_t             tag_out;

    // NOTE: defaults first in every always_comb so no path infers a latch.
    always_comb begin
        core_gnt = 1'b0;
        ext_gnt  = 1'b0;
        if (reset) begin
            case (state)
                NORMAL: begin
                    core_gnt = bus.core_req;
                    ext_gnt  = bus.ext_req & ~bus.core_req;
                end
                EXT_FORCE, EXT_LOCK: ext_gnt = bus.ext_req;
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.mem_wr    = 1'b0;
        bus.mem_rd_wr = '0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        if (core_gnt) begin
            bus.mem_wr    = bus.core_we;
            bus.mem_rd_wr = bus.core_size;
            bus.mem_addr  = bus.core_addr;
            bus.mem_wdata = bus.core_wdata;
        end else if (ext_gnt) begin
            bus.mem_wr    = bus.ext_we;
            bus.mem_rd_wr = bus.ext_size;
            bus.mem_addr  = bus.ext_addr;
            bus.mem_wdata = bus.ext_wdata;
        end
    end

    assign bus.mem_en     = core_gnt | ext_gnt;
    assign bus.core_gnt   = core_gnt;
    assign bus.ext_gnt    = ext_gnt;
    assign bus.core_stall = bus.core_req & ~core_gnt;

    assign ext_wait = bus.ext_req & ~ext_gnt;
    assign cnt_next = !ext_wait          ? '0  :
                      (starve_cnt == LIM) ? LIM : starve_cnt + 1'b1;

    // The forced slot lands in the cycle right after the counter hits the limit.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= NORMAL;
            starve_cnt <= '0;
        end else begin
            starve_cnt <= cnt_next;
            case (state)
                NORMAL: begin
                    if (ext_gnt && bus.ext_lock) state <= EXT_LOCK;
                    else if (cnt_next == LIM)    state <= EXT_FORCE;
                end
                EXT_FORCE: state <= (ext_gnt && bus.ext_lock) ? EXT_LOCK : NORMAL;
                EXT_LOCK:  if (!bus.ext_lock) state <= NORMAL;
                default:   state <= NORMAL;
            endcase
        end
    end

    assign tag_in = '{valid: bus.mem_en & ~bus.mem_wr,
                      owner: ext_gnt ? OWN_EXT : OWN_CORE};

    arb_tag_pipe #(
        .MEM_LAT (MEM_LAT)
    ) u_tag_pipe (
        .clock   (clock),
        .reset   (reset),
        .tag_in  (tag_in),
        .tag_out (tag_out)
    );

    assign bus.core_rvalid = tag_out.valid & (tag_out.owner == OWN_CORE);
    assign bus.ext_rvalid  = tag_out.valid & (tag_out.owner == OWN_EXT);
    assign bus.core_rdata  = bus.core_rvalid ? bus.mem_rdata : '0;
    assign bus.ext_rdata   = bus.ext_rvalid  ? bus.mem_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: one instance at MEM_LAT=1 and one at MEM_LAT=3
// share all stimulus; each is checked against hand-computed expectations.
module tb_dmem_arbiter;
    import dmem_arb_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b0;

    logic        core_req   = 1'b0;
    logic        core_we    = 1'b0;
    logic [2:0]  core_size  = RW_WORD;
    logic [31:0] core_addr  = '0;
    logic [31:0] core_wdata = '0;
    logic        ext_req    = 1'b0;
    logic        ext_we     = 1'b0;
    logic [2:0]  ext_size   = RW_WORD;
    logic [31:0] ext_addr   = '0;
    logic [31:0] ext_wdata  = '0;
    logic        ext_lock   = 1'b0;
    logic [31:0] mem_rdata  = '0;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus1 ();
    dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus3 ();

    assign bus1.core_req   = core_req;
    assign bus1.core_we    = core_we;
    assign bus1.core_size  = core_size;
    assign bus1.core_addr  = core_addr;
    assign bus1.core_wdata = core_wdata;
    assign bus1.ext_req    = ext_req;
    assign bus1.ext_we     = ext_we;
    assign bus1.ext_size   = ext_size;
    assign bus1.ext_addr   = ext_addr;
    assign bus1.ext_wdata  = ext_wdata;
    assign bus1.ext_lock   = ext_lock;
    assign bus1.mem_rdata  = mem_rdata;

    assign bus3.core_req   = core_req;
    assign bus3.core_we    = core_we;
    assign bus3.core_size  = core_size;
    assign bus3.core_addr  = core_addr;
    assign bus3.core_wdata = core_wdata;
    assign bus3.ext_req    = ext_req;
    assign bus3.ext_we     = ext_we;
    assign bus3.ext_size   = ext_size;
    assign bus3.ext_addr   = ext_addr;
    assign bus3.ext_wdata  = ext_wdata;
    assign bus3.ext_lock   = ext_lock;
    assign bus3.mem_rdata  = mem_rdata;

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .STARVE_LIM(8)) u_dut1 (
        .clock (clock),
        .reset (reset),
        .bus   (bus1)
    );

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3), .STARVE_LIM(8)) u_dut3 (
        .clock (clock),
        .reset (reset),
        .bus   (bus3)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic sample();
        @(negedge clock);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        // Reset held with both requesters active: no grants, stall follows req.
        core_req = 1'b1;
        ext_req  = 1'b1;
        sample();
        check("rst_core_gnt", 64'(bus1.core_gnt), 64'd0);
        check("rst_ext_gnt", 64'(bus1.ext_gnt), 64'd0);
        check("rst_mem_en", 64'(bus1.mem_en), 64'd0);
        check("rst_mem_wr", 64'(bus1.mem_wr), 64'd0);
        check("rst_core_stall", 64'(bus1.core_stall), 64'd1);
        check("rst_rvalid", 64'({bus1.core_rvalid, bus1.ext_rvalid}), 64'd0);
        core_req = 1'b0;
        ext_req  = 1'b0;
        step();
        reset = 1'b1;
        sample();
        check("rst_state", 64'(u_dut1.state), 64'(NORMAL));
        check("rst_cnt", 64'(u_dut1.starve_cnt), 64'd0);
        for (int i = 0; i < 4; i++) step();

        // Core-only load at 0x10.
        core_req  = 1'b1;
        core_we   = 1'b0;
        core_addr = 32'h10;
        sample();
        check("core_gnt", 64'(bus1.core_gnt), 64'd1);
        check("core_mem_en", 64'(bus1.mem_en), 64'd1);
        check("core_mem_addr", 64'(bus1.mem_addr), 64'h10);
        check("core_mem_wr", 64'(bus1.mem_wr), 64'd0);
        check("core_stall0", 64'(bus1.core_stall), 64'd0);
        check("core_ext_gnt", 64'(bus1.ext_gnt), 64'd0);
        step();
        core_req  = 1'b0;
        mem_rdata = 32'hA5A5_0010;
        for (int k = 1; k <= 3; k++) begin
            sample();
            check($sformatf("co_rv1_%0d", k), 64'(bus1.core_rvalid), 64'(k == 1));
            check($sformatf("co_rd1_%0d", k), 64'(bus1.core_rdata), (k == 1) ? 64'hA5A5_0010 : 64'd0);
            check($sformatf("co_erv1_%0d", k), 64'(bus1.ext_rvalid), 64'd0);
            check($sformatf("co_rv3_%0d", k), 64'(bus3.core_rvalid), 64'(k == 3));
            check($sformatf("co_erv3_%0d", k), 64'(bus3.ext_rvalid), 64'd0);
            step();
        end

        // Contention: both stores held; ext forced at cycle 8.
        core_req = 1'b1; core_we = 1'b1; core_addr = 32'h20; core_wdata = 32'h1111_2222;
        ext_req  = 1'b1; ext_we  = 1'b1; ext_addr  = 32'h30; ext_wdata  = 32'h3333_4444;
        for (int i = 0; i <= 10; i++) begin
            sample();
            check($sformatf("cont_cgnt_%0d", i), 64'(bus1.core_gnt), 64'(i != 8));
            check($sformatf("cont_egnt_%0d", i), 64'(bus1.ext_gnt), 64'(i == 8));
            check($sformatf("cont_stall_%0d", i), 64'(bus1.core_stall), 64'(i == 8));
            check($sformatf("cont_addr_%0d", i), 64'(bus1.mem_addr), (i == 8) ? 64'h30 : 64'h20);
            check($sformatf("cont_egnt3_%0d", i), 64'(bus3.ext_gnt), 64'(i == 8));
            step();
        end
        core_req = 1'b0;
        ext_req  = 1'b0;
        step();

        // Locked ext stores at 0x40/0x44/0x48; core waits, then resumes.
        ext_req = 1'b1; ext_we = 1'b1; ext_lock = 1'b1; ext_addr = 32'h40;
        sample();
        check("lock_egnt0", 64'(bus1.ext_gnt), 64'd1);
        check("lock_wr0", 64'(bus1.mem_wr), 64'd1);
        check("lock_addr0", 64'(bus1.mem_addr), 64'h40);
        step();
        core_req = 1'b1; core_we = 1'b1; core_addr = 32'h80;
        ext_addr = 32'h44;
        sample();
        check("lock_state", 64'(u_dut1.state), 64'(EXT_LOCK));
        check("lock_egnt1", 64'(bus1.ext_gnt), 64'd1);
        check("lock_addr1", 64'(bus1.mem_addr), 64'h44);
        check("lock_stall1", 64'(bus1.core_stall), 64'd1);
        step();
        ext_addr = 32'h48;
        sample();
        check("lock_egnt2", 64'(bus1.ext_gnt), 64'd1);
        check("lock_addr2", 64'(bus1.mem_addr), 64'h48);
        check("lock_stall2", 64'(bus1.core_stall), 64'd1);
        step();
        ext_req  = 1'b0;
        ext_lock = 1'b0;
        sample();
        check("lock_cgnt3", 64'(bus1.core_gnt), 64'd0);
        check("lock_stall3", 64'(bus1.core_stall), 64'd1);
        check("lock_mem_en3", 64'(bus1.mem_en), 64'd0);
        step();
        sample();
        check("lock_cgnt4", 64'(bus1.core_gnt), 64'd1);
        check("lock_stall4", 64'(bus1.core_stall), 64'd0);
        check("lock_addr4", 64'(bus1.mem_addr), 64'h80);
        step();
        core_req = 1'b0;
        step();

        // Interleaved loads: core at T, ext at T+1, distinct return data per cycle.
        core_we  = 1'b0; core_addr = 32'h100;
        ext_we   = 1'b0; ext_addr  = 32'h200;
        for (int k = 0; k <= 5; k++) begin
            logic [31:0] d;
            d = 32'hD000_0000 + 32'(k);
            core_req  = (k == 0);
            ext_req   = (k == 1);
            mem_rdata = d;
            sample();
            if (k == 0) check("il_cgnt", 64'(bus1.core_gnt), 64'd1);
            if (k == 1) check("il_egnt", 64'(bus1.ext_gnt), 64'd1);
            check($sformatf("il1_crv_%0d", k), 64'(bus1.core_rvalid), 64'(k == 1));
            check($sformatf("il1_erv_%0d", k), 64'(bus1.ext_rvalid), 64'(k == 2));
            check($sformatf("il1_crd_%0d", k), 64'(bus1.core_rdata), (k == 1) ? 64'(d) : 64'd0);
            check($sformatf("il1_erd_%0d", k), 64'(bus1.ext_rdata), (k == 2) ? 64'(d) : 64'd0);
            check($sformatf("il3_crv_%0d", k), 64'(bus3.core_rvalid), 64'(k == 3));
            check($sformatf("il3_erv_%0d", k), 64'(bus3.ext_rvalid), 64'(k == 4));
            check($sformatf("il3_crd_%0d", k), 64'(bus3.core_rdata), (k == 3) ? 64'(d) : 64'd0);
            check($sformatf("il3_erd_%0d", k), 64'(bus3.ext_rdata), (k == 4) ? 64'(d) : 64'd0);
            step();
        end

        // Reset mid-flight: ext load issued, then reset for one cycle.
        ext_req = 1'b1; ext_we = 1'b0; ext_addr = 32'h300;
        mem_rdata = 32'hBEEF_0300;
        sample();
        check("mf_egnt", 64'(bus3.ext_gnt), 64'd1);
        step();
        reset    = 1'b0;
        core_req = 1'b1;
        sample();
        check("mf_gnt1", 64'({bus1.core_gnt, bus1.ext_gnt}), 64'd0);
        check("mf_gnt3", 64'({bus3.core_gnt, bus3.ext_gnt}), 64'd0);
        check("mf_mem_en", 64'(bus3.mem_en), 64'd0);
        check("mf_stall", 64'(bus3.core_stall), 64'd1);
        check("mf_erv", 64'({bus1.ext_rvalid, bus3.ext_rvalid}), 64'd0);
        step();
        reset    = 1'b1;
        core_req = 1'b0;
        ext_req  = 1'b0;
        for (int k = 2; k <= 6; k++) begin
            sample();
            if (k == 2) begin
                check("mf_state", 64'(u_dut3.state), 64'(NORMAL));
                check("mf_cnt", 64'(u_dut3.starve_cnt), 64'd0);
            end
            check($sformatf("mf_rv1_%0d", k), 64'({bus1.core_rvalid, bus1.ext_rvalid}), 64'd0);
            check($sformatf("mf_rv3_%0d", k), 64'({bus3.core_rvalid, bus3.ext_rvalid}), 64'd0);
            step();
        end

        // Idle for 20 cycles.
        for (int i = 0; i < 20; i++) begin
            sample();
            check($sformatf("idle_en_%0d", i), 64'({bus1.mem_en, bus3.mem_en}), 64'd0);
            check($sformatf("idle_wr_%0d", i), 64'({bus1.mem_wr, bus3.mem_wr}), 64'd0);
            check($sformatf("idle_rv_%0d", i),
                  64'({bus1.core_rvalid, bus1.ext_rvalid, bus3.core_rvalid, bus3.ext_rvalid}), 64'd0);
            check($sformatf("idle_cnt_%0d", i), 64'(u_dut1.starve_cnt), 64'd0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Arbitrates the single data-memory port between the core's memory stage and an external loader/debug master (program load, memory inspection).
- Sits between the execute-to-memory pipeline register outputs and the data memory; produces a stall back to the core hazard logic.
- Pipelined: one access issued per cycle; read data is returned to the owning requester after a fixed memory latency, tracked by an owner-tag pipeline.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- MEM_LAT, 1, cycles from issue to mem_rdata valid; legal range 1..4.
- STARVE_LIM, 8, consecutive cycles ext may wait before forced service.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- core_req  in  1  core access request; held until granted.
- core_we  in  1  1 = store, 0 = load.
- core_size  in  3  rd_wr_mem byte/half/word and sign encoding, passed through.
- core_addr  in  ADDR_W  byte address.
- core_wdata  in  DATA_W  store data.
- core_gnt  out  1  access issued this cycle.
- core_stall  out  1  core_req & ~core_gnt.
- core_rvalid  out  1  core load data valid.
- core_rdata  out  DATA_W  load data.
- ext_req, ext_we, ext_size, ext_addr, ext_wdata, ext_gnt, ext_rvalid, ext_rdata: same as core_*.
- ext_lock  in  1  ext requests exclusive ownership while high.
- mem_en  out  1  access issued.
- mem_wr  out  1  write strobe.
- mem_rd_wr  out  3  size encoding to memory.
- mem_addr  out  ADDR_W.
- mem_wdata  out  DATA_W.
- mem_rdata  in  DATA_W  valid MEM_LAT cycles after issue.

Behaviour:
- Reset (reset low, async): FSM to NORMAL, starve counter 0, tag pipeline cleared. All gnt, rvalid, mem_en and mem_wr are forced 0 while reset is low, regardless of inputs. Stall is still driven from req.
- gnt and mem_* are combinational from FSM state and requests. At most one gnt per cycle. mem_en = core_gnt | ext_gnt. mem_* mux selects the granted requester; when neither is granted, mem_* = 0.
- FSM states:
  - NORMAL: core has priority. ext is granted only when core_req = 0.
  - EXT_FORCE: ext granted unconditionally this cycle, core stalled. Next state is EXT_LOCK if ext_lock = 1 at that grant, else NORMAL.
  - EXT_LOCK: only ext is granted and core is stalled. Exit to NORMAL in the cycle after ext_lock samples 0.
- NORMAL -> EXT_FORCE when the starve counter reaches STARVE_LIM.
- NORMAL -> EXT_LOCK when ext is granted with ext_lock = 1.
- Starve counter:
  - Increments each cycle with ext_req & ~ext_gnt.
  - Clears on ext_gnt or when ext_req = 0.
  - Saturates at STARVE_LIM.
- Tag pipeline, MEM_LAT deep, shifted every cycle. Each entry holds {valid = mem_en & ~mem_wr, owner}.
  - At the output stage: x_rvalid = 1 for the tagged owner, and x_rdata = mem_rdata.
  - The non-owner's rdata is held at 0.
- Stores produce no rvalid. Writes issue in the grant cycle.
- Back-to-back mixed issue is legal: core load at T, ext load at T+1 returns core at T+MEM_LAT and ext at T+1+MEM_LAT.
- Reset mid-flight: outstanding loads are discarded and never return rvalid.
- Simultaneous ext_lock deassert and core_req in EXT_LOCK: that cycle still grants ext if ext_req; core is granted from the next cycle.
- Requesters must hold req and attributes stable until gnt. Changing them before gnt is a requester protocol error; behaviour is unspecified.

Decomposition:
- Package dmem_arb_pkg:
  - arb_state_e {NORMAL, EXT_FORCE, EXT_LOCK}.
  - owner_e {OWN_CORE, OWN_EXT}.
  - rd_wr_mem size encoding constants shared with the data memory and decoder.
- Sub-module arb_tag_pipe: parameterised MEM_LAT shift register of {valid, owner}, with async active-low clear.

Test Plan:
- Core-only: core load addr 0x10 at cycle 5, MEM_LAT=1 -> core_gnt at 5, mem_en=1, mem_addr=0x10, core_rvalid at 6 with mem_rdata. ext_rvalid stays 0.
- Contention: core_req and ext_req held high from cycle 0 -> core granted cycles 0-7, ext forced at cycle 8 (STARVE_LIM=8), core resumes at 9. core_stall=1 only at 8.
- Lock: ext store with ext_lock=1 at 0x40, 0x44, 0x48, ext_lock dropped after third gnt, core_req high throughout -> core_stall=1 for 3 cycles; core granted the cycle after lock samples 0.
- Interleaved loads, MEM_LAT=3: core load T, ext load T+1 (core_req low) -> core_rvalid T+3, ext_rvalid T+4, no cross-delivery.
- Reset mid-flight: ext load issued, reset low for 1 cycle before return -> no rvalid ever. FSM NORMAL, counter 0 after release.
- Idle: no requests for 20 cycles -> mem_en=0, mem_wr=0, all rvalid 0, starve counter 0.
